// File: rtl/mdu_issue_ctrl.sv
// Issue/hazard controller between E-stage decode and the multiply/divide unit.
// Define MDU_CTRL_FLUSH_EN to add a flush input that kills a request still in ISSUE.
module mdu_issue_ctrl #(
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10,
  parameter int unsigned WD_SLACK   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_rs,
  input  logic [31:0] req_rt,
  output logic        req_ready,
  output logic        stall,
  output logic        start,
  output logic [3:0]  MDUop,
  output logic [31:0] MDU_opA,
  output logic [31:0] MDU_opB,
  input  logic        mdu_busy,
`ifdef MDU_CTRL_FLUSH_EN
  input  logic        flush,
`endif
  output logic        wd_err
);

  localparam logic [4:0] MUL_LOAD = 5'(MUL_CYCLES + WD_SLACK);
  localparam logic [4:0] DIV_LOAD = 5'(DIV_CYCLES + WD_SLACK);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        first_q, first_d;
  logic        start_q, start_d;
  logic [3:0]  mduop_q, mduop_d;
  logic [31:0] opa_q, opa_d;
  logic [31:0] opb_q, opb_d;
  logic        wd_err_q, wd_err_d;
  logic        ready_w;
  logic        kill_w;
  logic        req_is_mdu;

`ifdef MDU_CTRL_FLUSH_EN
  assign kill_w = flush;
`else
  assign kill_w = 1'b0;
`endif

  // mfhi/mflo and illegal opcodes are accepted without touching the MDU
  assign req_is_mdu = (req_op >= 4'd1) && (req_op <= 4'd6);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    first_d  = 1'b0;
    start_d  = 1'b0;
    mduop_d  = 4'd0;
    opa_d    = opa_q;
    opb_d    = opb_q;
    wd_err_d = wd_err_q;
    ready_w  = 1'b0;

    case (state_q)
      IDLE: begin
        ready_w = !mdu_busy && !kill_w;
        if (req_valid && ready_w && req_is_mdu) begin
          state_d = ISSUE;
          start_d = 1'b1;
          mduop_d = req_op;
          opa_d   = req_rs;
          opb_d   = req_rt;
        end
      end

      ISSUE: begin
        if (kill_w) begin
          state_d = IDLE;
        end else if ((mduop_q == 4'd1) || (mduop_q == 4'd2)) begin
          cnt_d   = MUL_LOAD;
          first_d = 1'b1;
          state_d = WAIT;
        end else if ((mduop_q == 4'd3) || (mduop_q == 4'd4)) begin
          cnt_d   = DIV_LOAD;
          first_d = 1'b1;
          state_d = WAIT;
        end else begin
          state_d = IDLE;
        end
      end

      WAIT: begin
        cnt_d = (cnt_q != 5'd0) ? (cnt_q - 5'd1) : 5'd0;
        // busy is not trusted on the first WAIT cycle; the MDU may not have raised it yet
        if (!first_q && !mdu_busy) begin
          state_d = IDLE;
        end else if (cnt_q <= 5'd1) begin
          wd_err_d = 1'b1;
          state_d  = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= 5'd0;
      first_q  <= 1'b0;
      start_q  <= 1'b0;
      mduop_q  <= 4'd0;
      opa_q    <= 32'd0;
      opb_q    <= 32'd0;
      wd_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      first_q  <= first_d;
      start_q  <= start_d;
      mduop_q  <= mduop_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      wd_err_q <= wd_err_d;
    end
  end

  assign req_ready = ready_w;
  assign stall     = req_valid && !ready_w;
  assign start     = start_q && !kill_w;
  assign MDUop     = kill_w ? 4'd0 : mduop_q;
  assign MDU_opA   = opa_q;
  assign MDU_opB   = opb_q;
  assign wd_err    = wd_err_q;

endmodule
